// File: rtl/display_scan_if.sv
// Bus between a display_scan block and whatever supplies its values.
// The driver feeds value/load; display_scan returns busy and the scan outputs.
interface display_scan_if;
  logic [13:0] value;
  logic        load;
  logic        busy;
  logic [3:0]  num;
  logic [3:0]  an;

  modport master (output value, load, input busy, num, an);
  modport slave  (input value, load, output busy, num, an);
endinterface

// File: rtl/display_scan.sv
// Binary-to-BCD conversion (shift-add-3) with leading-zero blanking, feeding a
// 4-digit common-anode multiplexed display scanner.
module display_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic           clk,
  input  logic           rst_n,
  display_scan_if.slave  bus
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t            state, state_nxt;
  logic              done;
  logic [29:0]       sr;
  logic [29:0]       sr_adj;
  logic [29:0]       sr_shift;
  logic [3:0]        step;
  logic              ovr;
  logic [3:0][3:0]   digit;
  logic [CNT_W-1:0]  refcnt;
  logic [1:0]        idx;

  function automatic logic [15:0] add3(input logic [15:0] bcd);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
    end
    return r;
  endfunction

  // Nibbles above the most significant nonzero one go blank; ones digit always shown.
  function automatic logic [15:0] blank(input logic [15:0] bcd);
    if (bcd[15:12] != 4'd0)     return bcd;
    else if (bcd[11:8] != 4'd0) return {4'hF, bcd[11:0]};
    else if (bcd[7:4] != 4'd0)  return {8'hFF, bcd[7:0]};
    else                        return {12'hFFF, bcd[3:0]};
  endfunction

  assign sr_adj   = {add3(sr[29:14]), sr[13:0]};
  assign sr_shift = sr_adj << 1;

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: if (bus.load) state_nxt = CONV;
      CONV: begin
        if (step == 4'd13) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Conversion control: step counter, overrange flag, committed digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step  <= 4'd0;
      ovr   <= 1'b0;
      digit <= {4{4'hF}};
    end else if (state == IDLE) begin
      if (bus.load) begin
        step <= 4'd0;
        ovr  <= (bus.value > 14'd9999);
      end
    end else begin
      step <= step + 4'd1;
      if (done) digit <= ovr ? {4{4'hA}} : blank(sr_shift[29:14]);
    end
  end

  // Shift register holds data only, so it carries no reset
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (bus.load) sr <= {16'd0, bus.value};
    end else begin
      sr <= sr_shift;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refcnt <= '0;
      idx    <= 2'd0;
    end else if (refcnt == CNT_W'(REFRESH_DIV - 1)) begin
      refcnt <= '0;
      idx    <= idx + 2'd1;
    end else begin
      refcnt <= refcnt + 1'b1;
    end
  end

  assign bus.busy = (state == CONV);
  assign bus.an   = ~(4'b0001 << idx);
  assign bus.num  = digit[idx];

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with REFRESH_DIV=4: vector table for
// conversions plus hand-written reset, load-while-busy and abort sequences.
module tb_display_scan;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  display_scan_if bus ();

  display_scan #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] value;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Watch 16 cycles (a full frame at REFRESH_DIV=4) and check each digit slot
  task automatic check_display(input string name, input logic [15:0] exp);
    int idx;
    for (int k = 0; k < 16; k++) begin
      idx = -1;
      case (bus.an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        check({name, " an"}, {12'd0, bus.an}, 16'h000E);
      end else begin
        check($sformatf("%s slot%0d", name, idx), {12'd0, bus.num}, {12'd0, exp[idx*4 +: 4]});
      end
      tick();
    end
  endtask

  // Start a conversion and count busy cycles; optionally pulse load again
  // at busy cycle inject_at with inject_val.
  task automatic run_conv(input logic [13:0] v, input int inject_at,
                          input logic [13:0] inject_val, output int cycles);
    bus.value = v;
    bus.load  = 1'b1;
    tick();
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      cycles++;
      bus.load = (cycles == inject_at);
      if (cycles == inject_at) bus.value = inject_val;
      tick();
    end
    bus.load = 1'b0;
  endtask

  int cyc;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{14'd1234,  16'h1234};
    vecs[1] = '{14'd7,     16'hFFF7};
    vecs[2] = '{14'd0,     16'hFFF0};
    vecs[3] = '{14'd1005,  16'h1005};
    vecs[4] = '{14'd12000, 16'hAAAA};
    vecs[5] = '{14'd9999,  16'h9999};
    vecs[6] = '{14'd4321,  16'h4321};

    rst_n     = 1'b1;
    bus.value = 14'd0;
    bus.load  = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) tick();

    // Asynchronous reset mid-frame, between clock edges
    rst_n = 1'b0;
    #1;
    check("rst an",   {12'd0, bus.an},   16'h000E);
    check("rst num",  {12'd0, bus.num},  16'h000F);
    check("rst busy", {15'd0, bus.busy}, 16'h0000);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("scan an k=%0d", k), {12'd0, bus.an},
            {12'd0, ~(4'b0001 << ((k / 4) % 4))});
      check($sformatf("scan num k=%0d", k), {12'd0, bus.num}, 16'h000F);
    end

    for (int i = 0; i < 7; i++) begin
      run_conv(vecs[i].value, 0, 14'd0, cyc);
      check($sformatf("busy len v=%0d", vecs[i].value), 16'(cyc), 16'd14);
      check_display($sformatf("disp v=%0d", vecs[i].value), vecs[i].exp);
    end

    // Reset mid-conversion aborts and blanks; a fresh load then completes
    bus.value = 14'd8888;
    bus.load  = 1'b1;
    tick();
    bus.load = 1'b0;
    check("abort busy before", {15'd0, bus.busy}, 16'h0001);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("abort busy", {15'd0, bus.busy}, 16'h0000);
    #1 rst_n = 1'b1;
    check_display("abort disp", 16'hFFFF);
    run_conv(14'd8888, 0, 14'd0, cyc);
    check("reload busy len", 16'(cyc), 16'd14);
    check_display("reload disp", 16'h8888);

    // Load during conversion is dropped and does not extend busy
    run_conv(14'd1234, 5, 14'd5678, cyc);
    check("mid load busy len", 16'(cyc), 16'd14);
    check_display("mid load disp", 16'h1234);

    // Load sampled on the edge where busy falls is ignored
    run_conv(14'd4321, 14, 14'd5678, cyc);
    check("late load busy len", 16'(cyc), 16'd14);
    check("late load idle", {15'd0, bus.busy}, 16'h0000);
    tick();
    check("late load still idle", {15'd0, bus.busy}, 16'h0000);
    check_display("late load disp", 16'h4321);

    // Load right after busy falls is accepted
    run_conv(14'd1234, 0, 14'd0, cyc);
    run_conv(14'd5678, 0, 14'd0, cyc);
    check("b2b busy len", 16'(cyc), 16'd14);
    check_display("b2b disp", 16'h5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
